// File: rtl/log2_pkg.sv
// Shared types and constants for the iterative log2 unit.
// Holds the FSM state encoding, the counter-width helper and the most-negative result pattern.
// Pure declarations; no logic of its own.
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        FRAC = 2'd2
    } state_e;

    // Widest result (OIW+OFW) the pattern helper can build.
    localparam int MAX_YW = 128;

    // Bits needed to count n iterations (0..n-1); never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Most-negative two's-complement value of width yw: a one followed by zeros.
    function automatic logic [MAX_YW-1:0] y_most_neg(input int yw);
        logic [MAX_YW-1:0] r;
        r = '0;
        r[yw-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/lzc_w.sv
// MSB position encoder: index of the highest set bit of din_i plus an all-zero flag.
// Latency: purely combinational.
// Backpressure: none; no state.
module lzc_w #(
    parameter  int W  = 64,
    localparam int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  din_i,
    output logic [PW-1:0] msb_o,
    output logic          zero_o
);

    // Later (higher) set bits overwrite earlier ones, leaving the MSB index.
    always_comb begin
        msb_o  = '0;
        zero_o = (din_i == '0);
        for (int i = 0; i < W; i++) begin
            if (din_i[i]) begin
                msb_o = PW'(i);
            end
        end
    end

endmodule

// File: rtl/log2_iter.sv
// Iterative fixed-point log2: Q(IW.FW) unsigned in, Q(OIW.OFW) signed out; LOG2_ITER_ROUND_EN adds round-to-nearest.
// Latency: OFW+1 edges (OFW+2 with LOG2_ITER_ROUND_EN), 1 edge for a zero operand.
// Backpressure: iStart is ignored while oBusy=1; no queueing, a new start is accepted in the oValid cycle.
module log2_iter #(
    parameter int IW  = 32,
    parameter int FW  = 32,
    parameter int OIW = 8,
    parameter int OFW = 32
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iStart,
    input  logic [IW+FW-1:0]     iX,
    output logic                 oBusy,
    output logic                 oValid,
    output logic [OIW+OFW-1:0]   oY,
    output logic                 oZero
);

    import log2_pkg::*;

    localparam int W  = IW + FW;
    localparam int YW = OIW + OFW;
    localparam int PW = (W > 1) ? $clog2(W) : 1;
`ifdef LOG2_ITER_ROUND_EN
    // One extra squaring step produces the guard bit used for rounding.
    localparam int NIT = OFW + 1;
`else
    localparam int NIT = OFW;
`endif
    localparam int CW = cnt_width(NIT);

    localparam logic [MAX_YW-1:0] Y_MIN_FULL = y_most_neg(YW);
    localparam logic [YW-1:0]     Y_MIN      = Y_MIN_FULL[YW-1:0];
    localparam logic [YW-1:0]     Y_MAX      = ~Y_MIN;

    state_e          state_q, state_d;
    logic [W-1:0]    opnd_q,  opnd_d;
    logic [W-1:0]    m_q,     m_d;
    logic [OIW-1:0]  int_q,   int_d;
    logic [NIT-1:0]  frac_q,  frac_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [YW-1:0]   y_q,     y_d;
    logic            zero_q,  zero_d;
    logic            valid_q, valid_d;

    logic [PW-1:0]   lz_p;
    logic            lz_zero;
    logic [PW-1:0]   shamt;
    logic [31:0]     int_full;
    logic [2*W-1:0]  sq;
    logic            sq_bit;
    logic [NIT-1:0]  frac_new;
    logic [YW-1:0]   y_full;

    lzc_w #(.W(W)) u_lzc (
        .din_i  (opnd_q),
        .msb_o  (lz_p),
        .zero_o (lz_zero)
    );

    // Normalisation: shift the MSB to bit W-1; exponent is p - FW.
    assign shamt    = PW'(W - 1) - lz_p;
    assign int_full = 32'(lz_p) - 32'(FW);

    // Mantissa squaring: Q1.(W-1) * Q1.(W-1) -> Q2.(2W-2); bit 2W-1 set means m^2 >= 2.
    assign sq     = {{W{1'b0}}, m_q} * {{W{1'b0}}, m_q};
    assign sq_bit = sq[2*W-1];

    // Next-state and datapath updates for the IDLE/NORM/FRAC sequence.
    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        m_d      = m_q;
        int_d    = int_q;
        frac_d   = frac_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        frac_new = NIT'({frac_q, sq_bit});
        y_full   = '0;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    opnd_d  = iX;
                    state_d = NORM;
                end
            end

            NORM: begin
                if (lz_zero) begin
                    y_d     = Y_MIN;
                    zero_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    int_d   = int_full[OIW-1:0];
                    m_d     = opnd_q << shamt;
                    frac_d  = '0;
                    cnt_d   = '0;
                    state_d = FRAC;
                end
            end

            FRAC: begin
                m_d    = sq_bit ? sq[2*W-1:W] : sq[2*W-2:W-1];
                frac_d = frac_new;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(NIT - 1)) begin
`ifdef LOG2_ITER_ROUND_EN
                    // Drop the guard bit, then add it back as a ties-up round, saturating at +max.
                    y_full = {int_q, frac_new[NIT-1:1]};
                    if (frac_new[0] && (y_full != Y_MAX)) begin
                        y_d = y_full + 1'b1;
                    end else begin
                        y_d = y_full;
                    end
`else
                    y_full = {int_q, frac_new};
                    y_d    = y_full;
`endif
                    zero_d  = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; synchronous reset discards any operation in flight.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            m_q     <= '0;
            int_q   <= '0;
            frac_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            m_q     <= m_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign oBusy  = (state_q != IDLE);
    assign oValid = valid_q;
    assign oY     = y_q;
    assign oZero  = zero_q;

endmodule

// File: tb/tb_log2_iter.sv
// Directed bench for log2_iter at default parameters (IW=FW=32, OIW=8, OFW=32).
// Latency expectations follow LOG2_ITER_ROUND_EN when the bench is built with it.
// Inputs are driven away from the rising edge; outputs are sampled 1 time unit after it.
module tb_log2_iter;

`ifdef LOG2_ITER_ROUND_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif
    localparam int BUDGET = 200;

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic [63:0] iX;
    logic        oBusy;
    logic        oValid;
    logic [39:0] oY;
    logic        oZero;

    int n_cmp;
    int n_err;

    log2_iter #(.IW(32), .FW(32), .OIW(8), .OFW(32)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iStart (iStart),
        .iX     (iX),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oY     (oY),
        .oZero  (oZero)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Issue one request and wait for oValid; lat = edges after the accepting edge.
    task automatic run_op(input logic [63:0] x, output logic [39:0] y, output logic z, output int lat);
        logic got;
        @(negedge iCLK);
        iX     = x;
        iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < BUDGET) begin
            @(posedge iCLK);
            #1;
            lat++;
            if (oValid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL timeout x=%h: no oValid within %0d edges", x, BUDGET);
        end
        y = oY;
        z = oZero;
    endtask

    task automatic test_reset();
        iRST = 1'b1; iStart = 1'b0; iX = '0;
        repeat (3) @(posedge iCLK);
        #1;
        n_cmp++; if (oBusy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", oBusy); end
        n_cmp++; if (oValid !== 1'b0)  begin n_err++; $display("FAIL reset_valid got=%b exp=0", oValid); end
        n_cmp++; if (oY !== 40'h0)     begin n_err++; $display("FAIL reset_y got=%h exp=0", oY); end
        n_cmp++; if (oZero !== 1'b0)   begin n_err++; $display("FAIL reset_zero got=%b exp=0", oZero); end
        iRST = 1'b0;
    endtask

    task automatic test_powers();
        logic [39:0] y; logic z; int lat;
        run_op(64'h1_0000_0000, y, z, lat);
        n_cmp++; if (y !== 40'h00_0000_0000) begin n_err++; $display("FAIL one_y got=%h exp=0000000000", y); end
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL one_zero got=%b exp=0", z); end
        n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL one_latency got=%0d exp=%0d", lat, LAT); end
        run_op(64'h2_0000_0000, y, z, lat);
        n_cmp++; if (y !== 40'h01_0000_0000) begin n_err++; $display("FAIL two_y got=%h exp=0100000000", y); end
        run_op(64'h0_8000_0000, y, z, lat);
        n_cmp++; if (y !== 40'hFF_0000_0000) begin n_err++; $display("FAIL half_y got=%h exp=ff00000000", y); end
        run_op(64'h0000_0000_0000_0001, y, z, lat);
        n_cmp++; if (y !== 40'hE0_0000_0000) begin n_err++; $display("FAIL min_y got=%h exp=e000000000", y); end
        run_op(64'h8000_0000_0000_0000, y, z, lat);
        n_cmp++; if (y !== 40'h1F_0000_0000) begin n_err++; $display("FAIL max_y got=%h exp=1f00000000", y); end
    endtask

    task automatic test_fraction();
        logic [39:0] y; logic z; int lat; logic [39:0] d;
        run_op(64'h3_0000_0000, y, z, lat);
        d = y - 40'h01_95C0_1A39;
        n_cmp++;
        if (!(d == 40'h0 || d == 40'h1 || d == 40'hFF_FFFF_FFFF)) begin
            n_err++; $display("FAIL three_y got=%h exp=0195c01a39 +-1", y);
        end
        n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL three_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_zero();
        logic [39:0] y; logic z; int lat;
        run_op(64'h0, y, z, lat);
        n_cmp++; if (y !== 40'h80_0000_0000) begin n_err++; $display("FAIL zero_y got=%h exp=8000000000", y); end
        n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL zero_flag got=%b exp=1", z); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        n_cmp++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL zero_busy got=%b exp=0", oBusy); end
    endtask

    task automatic test_busy_ignore();
        int nv; logic [39:0] ylast;
        @(negedge iCLK);
        iX = 64'h2_0000_0000; iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        repeat (5) @(posedge iCLK);
        @(negedge iCLK);
        n_cmp++; if (oBusy !== 1'b1) begin n_err++; $display("FAIL busy_mid got=%b exp=1", oBusy); end
        iX = 64'h0_8000_0000; iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        nv = 0; ylast = '0;
        for (int i = 0; i < 90; i++) begin
            @(posedge iCLK);
            #1;
            if (oValid === 1'b1) begin nv++; ylast = oY; end
        end
        n_cmp++; if (nv != 1) begin n_err++; $display("FAIL ignore_count got=%0d exp=1", nv); end
        n_cmp++; if (ylast !== 40'h01_0000_0000) begin n_err++; $display("FAIL ignore_y got=%h exp=0100000000", ylast); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] y; logic z; int lat; logic got;
        run_op(64'h1_0000_0000, y, z, lat);
        n_cmp++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_at_valid got=%b exp=0", oBusy); end
        iX = 64'h0_8000_0000; iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        n_cmp++; if (oBusy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b exp=1", oBusy); end
        n_cmp++; if (oValid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop got=%b exp=0", oValid); end
        lat = 0; got = 1'b0;
        while (!got && lat < BUDGET) begin
            @(posedge iCLK);
            #1;
            lat++;
            if (oValid === 1'b1) got = 1'b1;
        end
        n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (oY !== 40'hFF_0000_0000) begin n_err++; $display("FAIL b2b_y got=%h exp=ff00000000", oY); end
    endtask

    task automatic test_abort();
        int nv;
        @(negedge iCLK);
        iX = 64'h3_0000_0000; iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        repeat (10) @(posedge iCLK);
        #1 iRST = 1'b1;
        @(posedge iCLK);
        #1;
        n_cmp++; if (oBusy !== 1'b0)  begin n_err++; $display("FAIL abort_busy got=%b exp=0", oBusy); end
        n_cmp++; if (oValid !== 1'b0) begin n_err++; $display("FAIL abort_valid got=%b exp=0", oValid); end
        n_cmp++; if (oY !== 40'h0)    begin n_err++; $display("FAIL abort_y got=%h exp=0", oY); end
        n_cmp++; if (oZero !== 1'b0)  begin n_err++; $display("FAIL abort_zero got=%b exp=0", oZero); end
        iRST = 1'b0;
        nv = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge iCLK);
            #1;
            if (oValid === 1'b1) nv++;
        end
        n_cmp++; if (nv != 0) begin n_err++; $display("FAIL abort_no_valid got=%0d exp=0", nv); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        iRST = 1'b1; iStart = 1'b0; iX = '0;
        test_reset();
        test_powers();
        test_fraction();
        test_zero();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
